// File: rtl/ternary_prog_loader.sv
// Framed byte-stream loader: checks SYNC/length/checksum framing, packs three
// payload bytes into one 9-trit word and writes it into IMEM from address 0.
package ternary_pkg;
  typedef logic [1:0] trit_t;
  localparam trit_t T_ZERO    = 2'b00;
  localparam trit_t T_POS_ONE = 2'b01;
  localparam trit_t T_NEG_ONE = 2'b10;
endpackage

module ternary_prog_loader #(
  parameter int         IMEM_DEPTH     = 243,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  output logic                     prog_mode,
  output logic [7:0]               prog_addr,
  output ternary_pkg::trit_t [8:0] prog_data,
  output logic                     prog_we,
  output logic                     load_done,
  output logic                     load_error,
  output logic [7:0]               words_loaded
);
  import ternary_pkg::*;

  localparam int              TO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CSUM, S_ERROR} state_t;

  state_t          state, state_nx;
  logic            accept, byte_ok, to_hit;
  logic            start, wr_word, csum_good;
  logic [7:0]      len_q, csum_q;
  logic [1:0]      bcnt;
  logic [11:0]     word_q;
  logic [TO_W-1:0] to_cnt;

  // Payload bytes carry three trit codes in [5:0]; [7:6] must be clear.
  function automatic logic byte_legal(input logic [7:0] b);
    logic ok;
    ok = (b[7:6] == 2'b00);
    for (int k = 0; k < 3; k++) begin
      if (!(b[2*k +: 2] inside {T_ZERO, T_POS_ONE, T_NEG_ONE})) ok = 1'b0;
    end
    return ok;
  endfunction

  assign rx_ready = rst_n;
  assign accept   = rx_valid && rx_ready;
  assign byte_ok  = byte_legal(rx_data);
  assign to_hit   = (to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    start     = 1'b0;
    wr_word   = 1'b0;
    csum_good = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept && rx_data == SYNC_BYTE) begin
          state_nx = S_LEN;
          start    = 1'b1;
        end
      end
      S_LEN: begin
        if (accept) begin
          if (rx_data == 8'd0 || int'(rx_data) > IMEM_DEPTH) state_nx = S_ERROR;
          else                                                state_nx = S_PAYLOAD;
        end else if (to_hit) begin
          state_nx = S_ERROR;
        end
      end
      S_PAYLOAD: begin
        if (accept) begin
          if (!byte_ok) begin
            state_nx = S_ERROR;
          end else if (bcnt == 2'd2) begin
            wr_word = 1'b1;
            if (words_loaded + 8'd1 == len_q) state_nx = S_CSUM;
          end
        end else if (to_hit) begin
          state_nx = S_ERROR;
        end
      end
      S_CSUM: begin
        if (accept) begin
          if (rx_data == csum_q) begin
            csum_good = 1'b1;
            state_nx  = S_IDLE;
          end else begin
            state_nx = S_ERROR;
          end
        end else if (to_hit) begin
          state_nx = S_ERROR;
        end
      end
      S_ERROR: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prog_mode    <= 1'b0;
      prog_addr    <= '0;
      prog_data    <= '0;
      prog_we      <= 1'b0;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
      words_loaded <= '0;
      len_q        <= '0;
      csum_q       <= '0;
      bcnt         <= '0;
      word_q       <= '0;
      to_cnt       <= '0;
    end else begin
      prog_we   <= wr_word;
      load_done <= csum_good;
      if (start) begin
        prog_mode    <= 1'b1;
        load_error   <= 1'b0;
        prog_addr    <= '0;
        words_loaded <= '0;
        csum_q       <= '0;
        bcnt         <= '0;
      end else begin
        if (csum_good || state == S_ERROR) prog_mode <= 1'b0;
        if (state == S_ERROR) load_error <= 1'b1;
        // Address advances only once the strobe cycle has been seen by IMEM.
        if (prog_we) prog_addr <= prog_addr + 8'd1;
        if (wr_word) words_loaded <= words_loaded + 8'd1;
        if (state == S_PAYLOAD && accept) begin
          csum_q <= csum_q ^ rx_data;
          if (byte_ok) bcnt <= (bcnt == 2'd2) ? 2'd0 : bcnt + 2'd1;
          if (bcnt == 2'd0) word_q[5:0]  <= rx_data[5:0];
          if (bcnt == 2'd1) word_q[11:6] <= rx_data[5:0];
        end
      end
      if (wr_word) prog_data <= {rx_data[5:0], word_q};
      if (state == S_LEN && accept) len_q <= rx_data;
      if ((state == S_LEN || state == S_PAYLOAD || state == S_CSUM) && !accept)
        to_cnt <= to_cnt + 1'b1;
      else
        to_cnt <= '0;
    end
  end

endmodule

// File: doc/ternary_prog_loader.md
# ternary_prog_loader

Byte-stream program loader that sits directly upstream of `ternary_cpu_system` and drives its `prog_mode` / `prog_addr` / `prog_data` / `prog_we` instruction-memory load port. It accepts framed bytes from a UART receiver or other byte source over a valid/ready handshake. It checks each frame and unpacks every 3 payload bytes into one 9-trit instruction word, then writes the words into IMEM at consecutive addresses starting at 0. It reports completion or error to the board-level wrapper.

## Interface
Parameters:
- `IMEM_DEPTH`, 243, number of IMEM words; the upper bound on the frame length.
- `SYNC_BYTE`, 8'hA5, frame start marker.
- `TIMEOUT_CYCLES`, 1_000_000, maximum idle cycles between bytes inside a frame.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx_data` in 8: incoming byte.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: the loader can accept a byte. It is 0 while `rst_n` is low and 1 at all other times.
- `prog_mode` out 1: a load is in progress; this holds the CPU in programming mode.
- `prog_addr` out 8: binary IMEM word address.
- `prog_data` out `trit_t [8:0]` (18 bits): instruction word, trit 0 is the LSB.
- `prog_we` out 1: one-cycle IMEM write strobe.
- `load_done` out 1: one-cycle pulse when a frame ends with a good checksum.
- `load_error` out 1: sticky error flag.
- `words_loaded` out 8: number of words written in the current or last frame.

## Operation
- A byte is accepted on a rising `clk` edge when `rx_valid && rx_ready`.
- Frame format:
  - `SYNC_BYTE`
  - length byte N, the word count
  - 3·N payload bytes
  - checksum byte, equal to the XOR of all payload bytes.
- Payload byte j of a word carries trits 3j..3j+2. Trit k of the byte sits in bits [2k+1:2k] and uses the `ternary_pkg` codes (`T_ZERO`, `T_POS_ONE`, `T_NEG_ONE`). Bits [7:6] must be 0.
- FSM states: IDLE, LEN, PAYLOAD, CSUM, ERROR.
  - **IDLE:** bytes other than `SYNC_BYTE` are discarded. `SYNC_BYTE` moves to LEN, clears `load_error`, `words_loaded`, the address counter, the checksum accumulator and the byte-in-word counter, and sets `prog_mode`=1.
  - **LEN:** N=0 or N>`IMEM_DEPTH` moves to ERROR. Any other value latches N and moves to PAYLOAD.
  - **PAYLOAD:** each byte is XORed into the checksum and its trits are placed into the word register.
    - A byte with nonzero bits [7:6] or any trit code 2'b11 moves to ERROR, and no write occurs for that word.
    - On the third byte of a word the write is issued (see Timing), the address increments and `words_loaded` increments.
    - After word N the FSM moves to CSUM.
  - **CSUM:** if the byte matches the checksum, `load_done` pulses and the FSM returns to IDLE. On a mismatch it moves to ERROR.
  - **ERROR:** sets `load_error`=1 and returns to IDLE on the next cycle. Words already written stay in IMEM.
- Timeout: in LEN, PAYLOAD and CSUM a counter increments every cycle without an accepted byte and clears on each accepted byte. When it reaches `TIMEOUT_CYCLES`-1 the FSM moves to ERROR.
- `SYNC_BYTE` arriving inside a frame is treated as ordinary data; there is no resync.

## Timing
- Reset values: `prog_mode`=0, `prog_addr`=0, `prog_data`=all `T_ZERO`, `prog_we`=0, `load_done`=0, `load_error`=0, `words_loaded`=0, FSM in IDLE, `rx_ready`=0.
- `prog_mode` rises the cycle after `SYNC_BYTE` is accepted. It falls the cycle after the checksum byte is accepted or after the FSM enters ERROR.
- The write strobe:
  - `prog_we` is high for exactly one cycle, the cycle after the third byte of a word is accepted.
  - `prog_addr` and `prog_data` are stable during that cycle and hold their values afterwards.
  - `prog_addr` increments on the following cycle.
- `load_done` pulses in the same cycle that `prog_mode` falls on a good frame. `load_done` and `load_error` are never high in the same cycle.
- Back-to-back bytes, one per cycle, are accepted with no stalls. A write pulse can overlap acceptance of the next word's first byte.
- Reset mid-frame: all state clears immediately (asynchronously) and `prog_we` drops at once. A partial word is never written.

## Test plan
- **Good 2-word frame:** A5, 02, 6 payload bytes encoding +1…+1 and alternating −1/0, correct XOR -> `prog_we` pulses at addr 0 then addr 1 with the matching trits, `load_done`=1 for 1 cycle, `words_loaded`=2, `load_error`=0.
- **Bad checksum:** a 1-word frame with its checksum XORed by 0x01 -> one write at addr 0, `load_error`=1, no `load_done`, `prog_mode`=0 after the error.
- **Illegal length:** A5, 00, and separately A5, F4 (244) -> ERROR, no `prog_we`, `load_error`=1. The next valid frame clears `load_error` on its `SYNC_BYTE`.
- **Invalid trit:** a payload byte of 0x03 or 0x40 -> ERROR immediately, no write for that word.
- **Timeout:** with `TIMEOUT_CYCLES`=16, stop after 2 payload bytes -> `load_error`=1 after 16 idle cycles, `prog_mode`=0.
- **Reset mid-frame:** assert `rst_n`=0 between bytes 4 and 5 -> all outputs at reset values, and a following good frame loads from addr 0.
